dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_bridge_if.sv | 41 ++++
 rtl/dmem_align.sv | 12 +
 rtl/dmem_bridge.sv | 123 ++++++++++++
 tb/tb_dmem_bridge.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory bridge: FSM state encoding, access size codes,
// bus widths and the default WAIT watchdog limit.
package dmem_pkg;

    localparam int unsigned ADDR_W                 = 64;
    localparam int unsigned DATA_W                 = 64;
    localparam int unsigned STRB_W                 = DATA_W / 8;
    localparam int unsigned CNT_W                  = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    // Request captured in IDLE and replayed onto the bus from registers.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              we;
    } bus_req_t;

    function automatic logic is_misaligned(input size_e sz, input logic [2:0] lo);
        logic bad;
        case (sz)
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo[1:0];
            SZ_D:    bad = |lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core-side load/store signals and bus-side request/response signals of the bridge.
interface dmem_bridge_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              fault;

    logic              bus_req_valid;
    logic              bus_req_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [DATA_W-1:0] bus_wdata;
    logic [STRB_W-1:0] bus_wstrb;
    logic              bus_rsp_valid;
    logic              bus_rsp_err;
    logic [DATA_W-1:0] bus_rdata;

    // Bridge view.
    modport slave (
        input  req_valid, req_we, req_size, mem_addr, mem_wdata, mem_we,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
        output mem_rdata, stall, fault,
        output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb
    );

    // Core plus memory-bus environment view.
    modport master (
        output req_valid, req_we, req_size, mem_addr, mem_wdata, mem_we,
        output bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
        input  mem_rdata, stall, fault,
        input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb
    );

endinterface

// File: rtl/dmem_align.sv
// Right-justifies a bus read beat by the byte offset of the access, zero-filling the top.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        off_i,
    output logic [DATA_W-1:0] data_o
);

    assign data_o = data_i >> {off_i, 3'b000};

endmodule

// File: rtl/dmem_bridge.sv
// Load/store unit to 64-bit memory bus bridge (IDLE/ISSUE/WAIT/DONE).
// Define DMEM_BRIDGE_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES cycles.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    dmem_bridge_if.slave  bif
);

    // The watchdog counter is CNT_W bits wide, which bounds the usable limit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << CNT_W)) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYCLES out of range");
    end

    state_e            state_q, state_d;
    bus_req_t          req_q, req_d;
    logic              breq_q, breq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [DATA_W-1:0] rdata_aligned;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    dmem_align u_align (
        .data_i (bif.bus_rdata),
        .off_i  (req_q.addr[2:0]),
        .data_o (rdata_aligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            breq_q  <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            breq_q  <= breq_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Result registers load only on entry to DONE, so they read zero in every other state.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = '0;
        fault_d = 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bif.req_valid) begin
                    if (is_misaligned(size_e'(bif.req_size), bif.mem_addr[2:0])) begin
                        state_d = ST_DONE;
                        fault_d = 1'b1;
                    end else begin
                        req_d.addr  = bif.mem_addr;
                        req_d.wdata = bif.mem_wdata;
                        req_d.wstrb = bif.mem_we & {STRB_W{bif.req_we}};
                        req_d.we    = bif.req_we;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bif.bus_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bif.bus_rsp_valid) begin
                    state_d = ST_DONE;
                    fault_d = bif.bus_rsp_err;
                    rdata_d = bif.bus_rsp_err ? '0 : rdata_aligned;
                end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        breq_d = (state_d == ST_ISSUE);
    end

    assign bif.bus_req_valid = breq_q;
    assign bif.bus_addr      = {req_q.addr[ADDR_W-1:3], 3'b000};
    assign bif.bus_we        = req_q.we;
    assign bif.bus_wdata     = req_q.wdata;
    assign bif.bus_wstrb     = req_q.wstrb;
    assign bif.mem_rdata     = rdata_q;
    assign bif.fault         = fault_q;

    // Stall must respond in the same cycle the core raises req_valid.
    assign bif.stall = ((state_q == ST_IDLE) & bif.req_valid)
                     | (state_q == ST_ISSUE)
                     | (state_q == ST_WAIT);

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: a scoreboard of expected DONE results checked by assertions.
module tb_dmem_bridge;
    import dmem_pkg::*;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = TIMEOUT_CYCLES_DEFAULT;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_bridge_if bif ();

    dmem_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".stall"}, 64'(bif.stall), 64'd0);
        check({tag, ".fault"}, 64'(bif.fault), 64'd0);
        check({tag, ".rdata"}, bif.mem_rdata, 64'd0);
        check({tag, ".breq"},  64'(bif.bus_req_valid), 64'd0);
    endtask

    // One access from request to DONE; bus responds per ready_delay / give_rsp.
    task automatic run_txn(
        input string       tag,
        input logic        we,
        input logic [1:0]  sz,
        input logic [63:0] addr,
        input logic [63:0] wdata,
        input logic [7:0]  be,
        input int          ready_delay,
        input bit          give_rsp,
        input logic [63:0] rdata,
        input logic        err,
        input bit          noise,
        input bit          exp_bus,
        input logic [63:0] exp_baddr,
        input logic [7:0]  exp_strb,
        input logic [63:0] exp_rdata,
        input logic        exp_fault,
        input int          exp_stalls
    );
        exp_t e;
        int   stalls   = 0;
        int   waited   = 0;
        bit   accepted = 1'b0;
        bit   seen     = 1'b0;
        bit   done     = 1'b0;
        e.rdata  = exp_rdata;
        e.fault  = exp_fault;
        e.stalls = exp_stalls;
        sb.push_back(e);

        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_we    = we;
        bif.req_size  = sz;
        bif.mem_addr  = addr;
        bif.mem_wdata = wdata;
        bif.mem_we    = be;
        #1;
        for (int c = 0; c < 60 && !done; c++) begin
            if (!bif.stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                bif.bus_req_ready = 1'b0;
                bif.bus_rsp_valid = 1'b0;
                bif.bus_rsp_err   = 1'b0;
                check({tag, ".rdata_stall"}, bif.mem_rdata, 64'd0);
                if (bif.bus_req_valid) begin
                    seen = 1'b1;
                    check({tag, ".bus_addr"},  bif.bus_addr, exp_baddr);
                    check({tag, ".bus_wstrb"}, 64'(bif.bus_wstrb), 64'(exp_strb));
                    check({tag, ".bus_we"},    64'(bif.bus_we), 64'(we));
                    check({tag, ".bus_wdata"}, bif.bus_wdata, wdata);
                    if (waited >= ready_delay) begin
                        bif.bus_req_ready = 1'b1;
                        accepted = 1'b1;
                    end else begin
                        waited++;
                        if (noise) begin
                            bif.bus_rsp_valid = 1'b1;
                            bif.bus_rsp_err   = 1'b1;
                            bif.bus_rdata     = 64'hBADD_BADD_BADD_BADD;
                        end
                    end
                end else if (accepted && give_rsp) begin
                    bif.bus_rsp_valid = 1'b1;
                    bif.bus_rsp_err   = err;
                    bif.bus_rdata     = rdata;
                end
                @(negedge clk);
                #1;
            end
        end
        bif.bus_req_ready = 1'b0;
        bif.bus_rsp_valid = 1'b0;
        bif.bus_rsp_err   = 1'b0;
        check({tag, ".reached_done"}, 64'(done), 64'd1);
        e = sb.pop_front();
        if (done) begin
            check({tag, ".stall_cycles"}, 64'(stalls), 64'(e.stalls));
            check({tag, ".mem_rdata"},    bif.mem_rdata, e.rdata);
            check({tag, ".fault"},        64'(bif.fault), 64'(e.fault));
            check({tag, ".bus_issued"},   64'(seen), 64'(exp_bus));
        end
        bif.req_valid = 1'b0;
        @(negedge clk);
        #1;
        check_quiet({tag, ".after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.req_valid     = 1'b0;
        bif.req_we        = 1'b0;
        bif.req_size      = 2'b00;
        bif.mem_addr      = '0;
        bif.mem_wdata     = '0;
        bif.mem_we        = '0;
        bif.bus_req_ready = 1'b0;
        bif.bus_rsp_valid = 1'b0;
        bif.bus_rsp_err   = 1'b0;
        bif.bus_rdata     = '0;
        #1;
        check_quiet("reset");
        check("reset.bus_addr",  bif.bus_addr, 64'd0);
        check("reset.bus_wstrb", 64'(bif.bus_wstrb), 64'd0);
        check("reset.bus_we",    64'(bif.bus_we), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Stray response while idle must be ignored.
        @(negedge clk);
        bif.bus_rsp_valid = 1'b1;
        bif.bus_rsp_err   = 1'b1;
        bif.bus_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        bif.bus_rsp_valid = 1'b0;
        bif.bus_rsp_err   = 1'b0;
        #1;
        check_quiet("idle_rsp");
        @(negedge clk);
        #1;
        check_quiet("idle_rsp2");

        run_txn("sd", 1'b1, SZ_D, 64'h1000, 64'h1122_3344_5566_7788, 8'hFF,
                0, 1'b1, 64'd0, 1'b0, 1'b0,
                1'b1, 64'h1000, 8'hFF, 64'd0, 1'b0, 3);
        run_txn("lb", 1'b0, SZ_B, 64'h2003, 64'd0, 8'h08,
                0, 1'b1, 64'h8877_6655_4433_2211, 1'b0, 1'b0,
                1'b1, 64'h2000, 8'h00, 64'h0000_0088_7766_5544, 1'b0, 3);
        run_txn("lw_mis", 1'b0, SZ_W, 64'h2002, 64'd0, 8'h0F,
                0, 1'b1, 64'd0, 1'b0, 1'b0,
                1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1);
        run_txn("lh_mis", 1'b0, SZ_H, 64'h2001, 64'd0, 8'h03,
                0, 1'b1, 64'd0, 1'b0, 1'b0,
                1'b0, 64'd0, 8'h00, 64'd0, 1'b1, 1);
        run_txn("lh", 1'b0, SZ_H, 64'h2002, 64'd0, 8'h00,
                0, 1'b1, 64'h0102_0304_0506_0708, 1'b0, 1'b0,
                1'b1, 64'h2000, 8'h00, 64'h0000_0102_0304_0506, 1'b0, 3);
        run_txn("lw", 1'b0, SZ_W, 64'h5004, 64'd0, 8'hF0,
                0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0,
                1'b1, 64'h5000, 8'h00, 64'h0000_0000_DEAD_BEEF, 1'b0, 3);
        run_txn("sb", 1'b1, SZ_B, 64'h4004, 64'h5A5A_5A5A_5A5A_5A5A, 8'h10,
                2, 1'b1, 64'd0, 1'b0, 1'b0,
                1'b1, 64'h4000, 8'h10, 64'd0, 1'b0, 5);
        run_txn("ld_err", 1'b0, SZ_D, 64'h3000, 64'd0, 8'h00,
                5, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1,
                1'b1, 64'h3000, 8'h00, 64'd0, 1'b1, 8);

        // Reset while in WAIT, then a late response after reset release.
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b0;
        bif.req_size  = SZ_D;
        bif.mem_addr  = 64'h6000;
        bif.mem_we    = 8'h00;
        @(negedge clk);
        #1;
        check("rst_wait.issue_breq", 64'(bif.bus_req_valid), 64'd1);
        bif.bus_req_ready = 1'b1;
        @(negedge clk);
        bif.bus_req_ready = 1'b0;
        #1;
        check("rst_wait.in_wait_stall", 64'(bif.stall), 64'd1);
        check("rst_wait.in_wait_breq",  64'(bif.bus_req_valid), 64'd0);
        rst           = 1'b0;
        bif.req_valid = 1'b0;
        #1;
        check_quiet("rst_wait.during");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bif.bus_rsp_valid = 1'b1;
        bif.bus_rsp_err   = 1'b1;
        bif.bus_rdata     = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        bif.bus_rsp_valid = 1'b0;
        bif.bus_rsp_err   = 1'b0;
        #1;
        check_quiet("rst_wait.late_rsp");
        @(negedge clk);
        #1;
        check_quiet("rst_wait.late_rsp2");

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        run_txn("timeout", 1'b0, SZ_D, 64'h7000, 64'd0, 8'h00,
                0, 1'b0, 64'd0, 1'b0, 1'b0,
                1'b1, 64'h7000, 8'h00, 64'd0, 1'b1, 2 + TB_TIMEOUT);
`endif

        run_txn("ld_after", 1'b0, SZ_D, 64'h8008, 64'd0, 8'h00,
                0, 1'b1, 64'hA5A5_0000_1111_2222, 1'b0, 1'b0,
                1'b1, 64'h8008, 8'h00, 64'hA5A5_0000_1111_2222, 1'b0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
